// File: rtl/mlp_layer_sequencer_fp.sv
// Layer sequencer: time-multiplexes one Q8.8 MAC neuron across the
// NUM_NEURONS outputs of a fully-connected layer.
// Ports:
//   in_valid/in_ready/in_act      activation vector handshake
//   wmem_rd_en/wmem_addr          weight memory read (data 1 cycle later)
//   wmem_w_row/wmem_bias          weight row and bias for wmem_addr
//   mac_valid_in/mac_a/w/bias     start pulse and operands to the MAC
//   mac_valid_out/mac_result      MAC result pulse
//   out_valid/out_ready/out_act   output vector handshake
//   busy                          not IDLE
//   err_timeout                   sticky MAC timeout flag
module mlp_layer_sequencer_fp #(
   parameter int INPUT_WIDTH = 3,
   parameter int NUM_NEURONS = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int RELU_EN     = 1,
   parameter int MAC_TIMEOUT = 64
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [INPUT_WIDTH*DATA_WIDTH-1:0]   in_act,
   output logic                                wmem_rd_en,
   output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] wmem_addr,
   input  logic [INPUT_WIDTH*DATA_WIDTH-1:0]   wmem_w_row,
   input  logic [DATA_WIDTH-1:0]               wmem_bias,
   output logic                                mac_valid_in,
   output logic [INPUT_WIDTH*DATA_WIDTH-1:0]   mac_a,
   output logic [INPUT_WIDTH*DATA_WIDTH-1:0]   mac_w,
   output logic [DATA_WIDTH-1:0]               mac_bias,
   input  logic                                mac_valid_out,
   input  logic [DATA_WIDTH-1:0]               mac_result,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NUM_NEURONS*DATA_WIDTH-1:0]   out_act,
   output logic                                busy,
   output logic                                err_timeout
);

   localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int VW = INPUT_WIDTH * DATA_WIDTH;
   localparam int OW = NUM_NEURONS * DATA_WIDTH;
   localparam int TW = $clog2(MAC_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_STORE,
      S_OUTPUT
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         n_q, n_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic                  err_q, err_d;
   logic [VW-1:0]         act_q, act_d;
   logic [VW-1:0]         w_q, w_d;
   logic [DATA_WIDTH-1:0] bias_q, bias_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic [OW-1:0]         out_q, out_d;
   logic [DATA_WIDTH-1:0] res_relu;

   // Negative results clamp to zero only when ReLU is enabled.
   assign res_relu = ((RELU_EN != 0) && res_q[DATA_WIDTH-1]) ?
                     '0 : res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         tmr_q   <= '0;
         err_q   <= 1'b0;
         act_q   <= '0;
         w_q     <= '0;
         bias_q  <= '0;
         res_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         tmr_q   <= tmr_d;
         err_q   <= err_d;
         act_q   <= act_d;
         w_q     <= w_d;
         bias_q  <= bias_d;
         res_q   <= res_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      tmr_d   = tmr_q;
      err_d   = err_q;
      act_d   = act_q;
      w_d     = w_q;
      bias_d  = bias_q;
      res_d   = res_q;
      out_d   = out_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               act_d   = in_act;
               n_d     = '0;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            w_d     = wmem_w_row;
            bias_d  = wmem_bias;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            tmr_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the last allowed cycle still wins.
            if (mac_valid_out) begin
               res_d   = mac_result;
               state_d = S_STORE;
            end else if (tmr_q == TW'(MAC_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_STORE: begin
            out_d[n_q*DATA_WIDTH +: DATA_WIDTH] = res_relu;
            if (n_q == AW'(NUM_NEURONS - 1)) begin
               state_d = S_OUTPUT;
            end else begin
               n_d     = n_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready     = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign wmem_rd_en   = (state_q == S_FETCH);
   assign wmem_addr    = n_q;
   assign mac_valid_in = (state_q == S_ISSUE);
   assign mac_a        = act_q;
   assign mac_w        = w_q;
   assign mac_bias     = bias_q;
   assign out_valid    = (state_q == S_OUTPUT);
   assign out_act      = out_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_mlp_layer_sequencer_fp.sv
// Directed testbench for mlp_layer_sequencer_fp: two instances
// (ReLU on / off) run in lockstep against a behavioural 4-cycle MAC.
module tb_mlp_layer_sequencer_fp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, out_ready, mac_en;
   logic [47:0] in_act;

   logic        in_ready [2];
   logic        rd_en    [2];
   logic [0:0]  addr     [2];
   logic [47:0] wrow     [2];
   logic [15:0] wbias    [2];
   logic        vi       [2];
   logic [47:0] mac_a    [2];
   logic [47:0] mac_w    [2];
   logic [15:0] mac_b    [2];
   logic        vo       [2];
   logic [15:0] mac_res  [2];
   logic        ov       [2];
   logic [31:0] out_act  [2];
   logic        busy     [2];
   logic        err      [2];
   int          mcnt     [2];

   logic [47:0] rows   [2];
   logic [15:0] biases [2];

   int checks = 0;
   int errors = 0;

   int   lat, rd_n, vi_n;
   logic addr_bad, hold_bad, waiting, err_at1;
   logic [47:0] snap_a, snap_w;

   localparam logic [47:0] VEC_A = {16'h0100, 16'h0200, 16'hFF00};
   localparam logic [47:0] VEC_B = {16'h0300, 16'hFF80, 16'h0040};
   localparam logic [47:0] ROW0  = {16'h0080, 16'h0080, 16'h0080};
   localparam logic [47:0] ROW1  = {16'hFF00, 16'h0000, 16'h0000};

   mlp_layer_sequencer_fp #(
      .INPUT_WIDTH(3), .NUM_NEURONS(2), .DATA_WIDTH(16),
      .RELU_EN(1), .MAC_TIMEOUT(8)
   ) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready[0]), .in_act(in_act),
      .wmem_rd_en(rd_en[0]), .wmem_addr(addr[0]),
      .wmem_w_row(wrow[0]), .wmem_bias(wbias[0]),
      .mac_valid_in(vi[0]), .mac_a(mac_a[0]), .mac_w(mac_w[0]),
      .mac_bias(mac_b[0]), .mac_valid_out(vo[0]),
      .mac_result(mac_res[0]),
      .out_valid(ov[0]), .out_ready(out_ready), .out_act(out_act[0]),
      .busy(busy[0]), .err_timeout(err[0])
   );

   mlp_layer_sequencer_fp #(
      .INPUT_WIDTH(3), .NUM_NEURONS(2), .DATA_WIDTH(16),
      .RELU_EN(0), .MAC_TIMEOUT(8)
   ) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready[1]), .in_act(in_act),
      .wmem_rd_en(rd_en[1]), .wmem_addr(addr[1]),
      .wmem_w_row(wrow[1]), .wmem_bias(wbias[1]),
      .mac_valid_in(vi[1]), .mac_a(mac_a[1]), .mac_w(mac_w[1]),
      .mac_bias(mac_b[1]), .mac_valid_out(vo[1]),
      .mac_result(mac_res[1]),
      .out_valid(ov[1]), .out_ready(out_ready), .out_act(out_act[1]),
      .busy(busy[1]), .err_timeout(err[1])
   );

   function automatic logic [15:0] mac_calc(input logic [47:0] a,
                                            input logic [47:0] w,
                                            input logic [15:0] b);
      logic signed [39:0] acc;
      logic signed [31:0] p;
      logic signed [39:0] sh;
      acc = '0;
      for (int i = 0; i < 3; i++) begin
         p   = $signed(a[i*16 +: 16]) * $signed(w[i*16 +: 16]);
         acc = acc + p;
      end
      sh = acc >>> 8;
      return sh[15:0] + b;
   endfunction

   // Weight memory (1-cycle read) and MAC with valid_in-to-valid_out of 4.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            mcnt[k]    <= 0;
            vo[k]      <= 1'b0;
            mac_res[k] <= '0;
            wrow[k]    <= '0;
            wbias[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            vo[k] <= 1'b0;
            if (rd_en[k]) begin
               wrow[k]  <= rows[addr[k]];
               wbias[k] <= biases[addr[k]];
            end
            if (vi[k]) begin
               mcnt[k] <= 3;
            end else if (mcnt[k] > 0) begin
               mcnt[k] <= mcnt[k] - 1;
               if (mcnt[k] == 1 && mac_en) begin
                  vo[k]      <= 1'b1;
                  mac_res[k] <= mac_calc(mac_a[k], mac_w[k], mac_b[k]);
               end
            end
         end
      end
   end

   task automatic run_layer(input logic [47:0] act);
      @(negedge clk);
      in_act   = act;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_act   = 48'hA5A5_5A5A_C3C3;
      lat = 0; rd_n = 0; vi_n = 0;
      addr_bad = 1'b0; hold_bad = 1'b0; waiting = 1'b0;
      err_at1 = 1'bx;
      while (ov[0] !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == 1) err_at1 = err[0];
         if (rd_en[0] === 1'b1) begin
            if (32'(addr[0]) != rd_n) addr_bad = 1'b1;
            rd_n++;
         end
         if (vi[0] === 1'b1) begin
            vi_n++;
            snap_a  = mac_a[0];
            snap_w  = mac_w[0];
            waiting = 1'b1;
         end else if (waiting) begin
            if (mac_a[0] !== snap_a || mac_w[0] !== snap_w)
               hold_bad = 1'b1;
            if (vo[0] === 1'b1) waiting = 1'b0;
         end
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_act = '0; mac_en = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready[0], busy[0], ov[0], rd_en[0], vi[0], err[0]}
          !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 100000",
            {in_ready[0], busy[0], ov[0], rd_en[0], vi[0], err[0]});
      end
      checks++;
      if ({out_act[0], mac_a[0], mac_w[0], mac_b[0], addr[0]} !== '0) begin
         errors++;
         $display("FAIL reset_data: out_act %h mac_a %h mac_w %h want 0",
            out_act[0], mac_a[0], mac_w[0]);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_layer(VEC_A);
      checks++;
      if (lat != 17) begin
         errors++;
         $display("FAIL latency: got %0d want 17", lat);
      end
      checks++;
      if (out_act[0] !== 32'h0000_0100) begin
         errors++;
         $display("FAIL relu_on_out: got %h want 00000100", out_act[0]);
      end
      checks++;
      if (out_act[1] !== 32'hFF80_0100 || ov[1] !== 1'b1) begin
         errors++;
         $display("FAIL relu_off_out: got %h ov %b want ff800100 ov 1",
            out_act[1], ov[1]);
      end
   endtask

   task automatic test_backpressure();
      logic bad;
      logic [31:0] held;
      bad  = 1'b0;
      held = out_act[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0];
         in_act   = VEC_B;
         if (ov[0] !== 1'b1 || in_ready[0] !== 1'b0 ||
             out_act[0] !== held)
            bad = 1'b1;
      end
      in_valid = 1'b0;
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_hold: got %b want 0", bad);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if ({ov[0], in_ready[0], busy[0]} !== 3'b010) begin
         errors++;
         $display("FAIL handshake: got %b want 010",
            {ov[0], in_ready[0], busy[0]});
      end
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || out_act[0] !== 32'h0000_0100) begin
         errors++;
         $display("FAIL post_handshake: busy %b act %h want 0 00000100",
            busy[0], out_act[0]);
      end
   endtask

   task automatic test_strobes();
      run_layer(VEC_B);
      checks++;
      if (rd_n != 2 || addr_bad !== 1'b0) begin
         errors++;
         $display("FAIL rd_strobes: got %0d bad %b want 2 0",
            rd_n, addr_bad);
      end
      checks++;
      if (vi_n != 2) begin
         errors++;
         $display("FAIL mac_starts: got %0d want 2", vi_n);
      end
      checks++;
      if (hold_bad !== 1'b0) begin
         errors++;
         $display("FAIL wait_hold: got %b want 0", hold_bad);
      end
      checks++;
      if (mac_a[0] !== VEC_B) begin
         errors++;
         $display("FAIL mac_a_latch: got %h want %h", mac_a[0], VEC_B);
      end
      checks++;
      if (out_act[0] !== 32'h0000_0160 || out_act[1] !== 32'hFD80_0160)
      begin
         errors++;
         $display("FAIL vec_b_out: got %h %h want 00000160 fd800160",
            out_act[0], out_act[1]);
      end
      release_out();
   endtask

   task automatic test_timeout();
      logic ov_seen;
      int   n;
      mac_en = 1'b0;
      @(negedge clk);
      in_act   = VEC_A;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      ov_seen = 1'b0;
      while (err[0] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (ov[0] === 1'b1) ov_seen = 1'b1;
      end
      checks++;
      if (n != 12) begin
         errors++;
         $display("FAIL timeout_cycle: got %0d want 12", n);
      end
      checks++;
      if ({ov_seen, in_ready[0], busy[0]} !== 3'b010) begin
         errors++;
         $display("FAIL timeout_state: got %b want 010",
            {ov_seen, in_ready[0], busy[0]});
      end
      checks++;
      if (out_act[0] !== 32'h0000_0160) begin
         errors++;
         $display("FAIL timeout_keep: got %h want 00000160", out_act[0]);
      end
      mac_en = 1'b1;
      run_layer(VEC_A);
      checks++;
      if (err_at1 !== 1'b0 || err[0] !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got %b %b want 0 0", err_at1, err[0]);
      end
      checks++;
      if (out_act[1] !== 32'hFF80_0100 || lat != 17) begin
         errors++;
         $display("FAIL after_timeout: got %h lat %0d want ff800100 17",
            out_act[1], lat);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_act   = VEC_A;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (busy[0] !== 1'b1 || mac_w[0] !== ROW0) begin
         errors++;
         $display("FAIL in_wait: busy %b mac_w %h want 1 %h",
            busy[0], mac_w[0], ROW0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready[0], busy[0], ov[0], rd_en[0], vi[0], err[0]}
          !== 6'b100000) begin
         errors++;
         $display("FAIL async_rst_ctrl: got %b want 100000",
            {in_ready[0], busy[0], ov[0], rd_en[0], vi[0], err[0]});
      end
      checks++;
      if ({out_act[0], mac_a[0], mac_w[0], mac_b[0]} !== '0) begin
         errors++;
         $display("FAIL async_rst_data: out %h a %h w %h want 0",
            out_act[0], mac_a[0], mac_w[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready[0], busy[0]} !== 2'b10) begin
         errors++;
         $display("FAIL after_rst: got %b want 10",
            {in_ready[0], busy[0]});
      end
   endtask

   initial begin
      rows[0]   = ROW0;
      rows[1]   = ROW1;
      biases[0] = 16'h0000;
      biases[1] = 16'h0080;
      test_reset();
      test_basic();
      test_backpressure();
      test_strobes();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
